// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a ready/valid handshake and a two-entry skid buffer.
// in_ready and out_valid decode registered state only, so backpressure never forms a combinational path upstream.
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              take;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    assign occupancy = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            // Control is cleared so a flushed entry can never fire side effects; data is left alone.
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        state     <= FULL;
                    end else if (take) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a ready/valid handshake, a two-entry skid buffer, flush, and control-bit bubble masking. It replaces the fixed per-field enable registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage boundary is one instance carrying an opaque data bundle plus a control bundle. Backpressure is absorbed without a combinational ready path from the downstream stage to the upstream stage.

## Interface
Parameters:
- DATA_W, 64: width of datapath payload (PC_incr, ALU_out, write data, ...); never masked.
- CTRL_W, 8: width of control payload (regwrite, mem_read, mem_write, memtoreg, jumpl, halt, ...); forced to zero whenever the entry is invalid.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bits.
- flush  input  1  discard all held entries and the current input.
- out_valid  output  1  stage presents an entry downstream.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_data  output  DATA_W  presented payload.
- out_ctrl  output  CTRL_W  presented control; all-zero when out_valid=0.
- occupancy  output  2  number of held entries (0, 1, 2).

## Operation
- Storage: main entry (main_data, main_ctrl) drives the outputs; skid entry (skid_data, skid_ctrl) holds one overflow entry.
- Handshake:
  - accept = in_valid & in_ready.
  - take = out_valid & out_ready.
  - A transfer occurs only on a cycle where the corresponding pair is high.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - FULL: main and skid valid.
- Derived outputs:
  - in_ready = (state != FULL); depends on state only, never on out_ready.
  - out_valid = (state != EMPTY).
  - out_data = main_data.
  - out_ctrl = main_ctrl & {CTRL_W{out_valid}}.
- Transitions (no flush):
  - EMPTY: accept -> load main, go ONE; else stay.
  - ONE, accept & take: load main with input, stay ONE.
  - ONE, accept & !take: load skid with input, go FULL; main unchanged.
  - ONE, !accept & take: go EMPTY.
  - ONE, !accept & !take: hold.
  - FULL, take: move skid to main, go ONE (in_ready is 0, so no accept).
  - FULL, !take: hold.
- Flush:
  - Priority over every transition; next state EMPTY.
  - main_ctrl and skid_ctrl cleared to 0.
  - Input that cycle is discarded, even if accept is high.
  - A take on the flush cycle still completes downstream.
  - Data registers keep their contents.
- Reset:
  - Priority over flush; next state EMPTY.
  - All data and ctrl registers cleared to 0.
  - Applies mid-transfer; held entries are lost.
- Ordering: entries leave in strict arrival order; no entry is dropped or duplicated except by flush or reset.
- Control masking is the bubble mechanism: an invalid stage never asserts regwrite, mem_write or halt downstream.

## Timing
- Latency: 1 cycle. An entry accepted at edge N appears on out_* after edge N when the stage was EMPTY, or when in ONE with a simultaneous take.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- out_ready deasserted: the stage absorbs exactly one extra entry, then in_ready drops on the following cycle.
- in_ready recovers 1 cycle after the first take from FULL.
- Values after a reset edge:
  - in_ready=1, out_valid=0.
  - out_data=0, out_ctrl=0.
  - occupancy=0.
- Values after a flush edge: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- No combinational path from any input to in_ready or out_valid.

## Test plan
- Reset/idle: hold rst 2 cycles with in_valid=1, in_ctrl=8'hFF -> after release out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, feed data 1..8 back-to-back -> out_data 1..8 on consecutive cycles, one cycle after input, in_ready constantly 1.
- Backpressure: stream A,B,C with out_ready=0 from the cycle A appears on the outputs -> B captured in skid, in_ready=0, occupancy=2, C held upstream; release out_ready -> A, B, C emitted in order, no loss or duplicate.
- Flush in FULL: hold two entries with ctrl=8'h81, assert flush with in_valid=1 and new data -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed-cycle input never appears.
- Flush vs reset and take: flush with out_ready=1 in ONE -> downstream sees the take, stage EMPTY next cycle; assert rst and flush together in FULL -> data registers read 0 afterwards.
- Random: constrained-random in_valid/out_ready/flush for 10k cycles against a reference queue model -> order preserved, occupancy never exceeds 2, out_ctrl=0 whenever out_valid=0.
